// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command sequencer, the ALU and the bench.
// Contents:
//   - sequencer state encoding (ST_* localparams and state_t enum)
//   - ALU opcode values (6-bit)
//   - is_busy_state(): true for the states in which received bytes are dropped
package alu_ctrl_pkg;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_COMPUTE = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;

    typedef enum logic [2:0] {
        WAIT_A  = ST_WAIT_A,
        WAIT_B  = ST_WAIT_B,
        WAIT_OP = ST_WAIT_OP,
        COMPUTE = ST_COMPUTE,
        SEND    = ST_SEND,
        WAIT_TX = ST_WAIT_TX
    } state_t;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] NOR = 6'b100111;

    function automatic logic is_busy_state(input state_t s);
        return (s == COMPUTE) || (s == SEND) || (s == WAIT_TX);
    endfunction

endpackage

// File: rtl/alu_uart_sequencer_if.sv
// Bus between the sequencer and its surroundings (uart_rx, uart_tx, ALU).
// Signals:
//   i_rx_data / i_rx_valid : received byte, qualified by a one-cycle pulse
//   o_alu_a / o_alu_b / o_alu_opcode : registered ALU operands
//   i_alu_result           : combinational ALU result
//   o_tx_data / o_tx_start : result byte and one-cycle transmit start
//   i_tx_done              : one-cycle transmit completion pulse
//   o_busy, o_overrun, o_timeout : status
//   o_state                : current sequencer state (debug)
// Modports: master = sequencer side, slave = environment side.
//
// Handshake semantics: there is no ready signal on either side. A receive
// byte exists only in the cycle i_rx_valid is high; if the sequencer is busy
// it is dropped and o_overrun pulses one cycle later. o_tx_start is a
// one-cycle request with o_tx_data already stable; o_tx_data stays stable
// until i_tx_done pulses, and i_tx_done is honoured only while waiting for it.
interface alu_uart_sequencer_if
    import alu_ctrl_pkg::*;
#(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
);

    logic [NB_DATA-1:0]   i_rx_data;
    logic                 i_rx_valid;
    logic [NB_DATA-1:0]   o_alu_a;
    logic [NB_DATA-1:0]   o_alu_b;
    logic [NB_OPCODE-1:0] o_alu_opcode;
    logic [NB_DATA-1:0]   i_alu_result;
    logic [NB_DATA-1:0]   o_tx_data;
    logic                 o_tx_start;
    logic                 i_tx_done;
    logic                 o_busy;
    logic                 o_overrun;
    logic                 o_timeout;
    state_t               o_state;

    modport master (
        input  i_rx_data, i_rx_valid, i_alu_result, i_tx_done,
        output o_alu_a, o_alu_b, o_alu_opcode, o_tx_data, o_tx_start,
               o_busy, o_overrun, o_timeout, o_state
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_alu_result, i_tx_done,
        input  o_alu_a, o_alu_b, o_alu_opcode, o_tx_data, o_tx_start,
               o_busy, o_overrun, o_timeout, o_state
    );

endinterface

// File: rtl/inter_byte_timer.sv
// Idle-cycle counter used to abandon a partially received command.
// Ports:
//   i_clock   : clock, rising edge
//   i_reset   : asynchronous active-low reset
//   i_clear   : return the count to zero (has priority over i_enable)
//   i_enable  : count one idle cycle
//   o_expired : high in the cycle the count sits at TIMEOUT_CYCLES-1 while
//               enabled and not cleared (so a clear in that cycle wins)
module inter_byte_timer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int NB_TIMER       = 20
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [NB_TIMER-1:0] LAST = NB_TIMER'(TIMEOUT_CYCLES - 1);

    logic [NB_TIMER-1:0] count;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable) begin
            count <= count + NB_TIMER'(1);
        end
    end

    assign o_expired = i_enable && !i_clear && (count == LAST);

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects operand A, operand B and opcode bytes from the UART receiver,
// drives them to the shared ALU, latches the result and hands it to the UART
// transmitter, then waits for transmit completion before the next command.
// Ports:
//   i_clock : clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : alu_uart_sequencer_if.master (receive, ALU, transmit, status)
module alu_uart_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OPCODE      = 6,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int NB_TIMER       = 20
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    alu_uart_sequencer_if.master       bus
);

    state_t               state;
    logic [NB_DATA-1:0]   alu_a;
    logic [NB_DATA-1:0]   alu_b;
    logic [NB_OPCODE-1:0] alu_opcode;
    logic [NB_DATA-1:0]   tx_data;
    logic                 tx_start;
    logic                 busy;
    logic                 overrun;
    logic                 timeout;

    logic collecting;
    logic timer_clear;
    logic timer_expired;

    // The timer only runs between bytes of a command; any byte arriving in
    // the expiry cycle clears it, so the byte wins over the timeout.
    assign collecting  = (state == WAIT_B) || (state == WAIT_OP);
    assign timer_clear = bus.i_rx_valid || !collecting;

    inter_byte_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .NB_TIMER       (NB_TIMER)
    ) u_timer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (timer_clear),
        .i_enable  (collecting),
        .o_expired (timer_expired)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state      <= WAIT_A;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            timeout  <= 1'b0;
            // Busy states drop every received byte and flag it a cycle later.
            overrun  <= is_busy_state(state) && bus.i_rx_valid;

            case (state)
                WAIT_A: begin
                    if (bus.i_rx_valid) begin
                        alu_a <= bus.i_rx_data;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.i_rx_valid) begin
                        alu_b <= bus.i_rx_data;
                        state <= WAIT_OP;
                    end else if (timer_expired) begin
                        timeout <= 1'b1;
                        state   <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (bus.i_rx_valid) begin
                        alu_opcode <= bus.i_rx_data[NB_OPCODE-1:0];
                        busy       <= 1'b1;
                        state      <= COMPUTE;
                    end else if (timer_expired) begin
                        timeout <= 1'b1;
                        state   <= WAIT_A;
                    end
                end
                COMPUTE: begin
                    // Operands have been stable for a full cycle here.
                    tx_data  <= bus.i_alu_result;
                    tx_start <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        busy  <= 1'b0;
                        state <= WAIT_A;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= WAIT_A;
                end
            endcase
        end
    end

    assign bus.o_state      = state;
    assign bus.o_alu_a      = alu_a;
    assign bus.o_alu_b      = alu_b;
    assign bus.o_alu_opcode = alu_opcode;
    assign bus.o_tx_data    = tx_data;
    assign bus.o_tx_start   = tx_start;
    assign bus.o_busy       = busy;
    assign bus.o_overrun    = overrun;
    assign bus.o_timeout    = timeout;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Bench for alu_uart_sequencer: directed commands from the test plan, timeout
// and overrun corners, resets mid-command, then randomized commands. A
// behavioural ALU feeds the DUT and also produces expected result bytes.
module tb_alu_uart_sequencer;
  import alu_ctrl_pkg::*;

  localparam int NB_DATA   = 8;
  localparam int NB_OPCODE = 6;
  localparam int T         = 16;
  localparam int NB_TIMER  = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_uart_sequencer_if #(.NB_DATA(NB_DATA), .NB_OPCODE(NB_OPCODE)) bus ();

  alu_uart_sequencer #(
    .NB_DATA        (NB_DATA),
    .NB_OPCODE      (NB_OPCODE),
    .TIMEOUT_CYCLES (T),
    .NB_TIMER       (NB_TIMER)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  // behavioural ALU
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    logic [7:0] r;
    case (op)
      ADD:     r = a + b;
      SUB:     r = a - b;
      AND:     r = a & b;
      OR:      r = a | b;
      XOR:     r = a ^ b;
      SRA:     r = 8'($signed(a) >>> b);
      SRL:     r = a >> b;
      NOR:     r = ~(a | b);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign bus.i_alu_result = alu_ref(bus.o_alu_a, bus.o_alu_b, bus.o_alu_opcode);

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [NB_DATA-1:0] exp_q[$];
  int exp_overrun  = 0;
  int seen_overrun = 0;
  int exp_timeout  = 0;
  int seen_timeout = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_tx_start) begin
        if (exp_q.size() == 0) check("tx_spurious", 32'(bus.o_tx_start), 32'd0);
        else check("tx_data", 32'(bus.o_tx_data), 32'(exp_q.pop_front()));
      end
      if (bus.o_overrun) seen_overrun++;
      if (bus.o_timeout) seen_timeout++;
    end
  end

  // driver tasks (entered and left at a falling edge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.i_rx_data  = d;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask

  // Three bytes with 'gap' idle cycles between them; checks the start pulse
  // lands two cycles after the opcode byte. Leaves the bench in the SEND cycle.
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input int gap, input logic [7:0] exp);
    send_byte(a);
    idle(gap);
    send_byte(b);
    idle(gap);
    send_byte(opb);
    exp_q.push_back(exp);
    check("busy_compute", 32'(bus.o_busy), 32'd1);
    check("start_early", 32'(bus.o_tx_start), 32'd0);
    @(negedge clk);
    check("start_k2", 32'(bus.o_tx_start), 32'd1);
  endtask

  task automatic finish_tx(input int delay);
    idle(delay);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    check("busy_after_done", 32'(bus.o_busy), 32'd0);
    check("state_after_done", 32'(bus.o_state), 32'(WAIT_A));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_a"}, 32'(bus.o_alu_a), 32'd0);
    check({tag, "_b"}, 32'(bus.o_alu_b), 32'd0);
    check({tag, "_op"}, 32'(bus.o_alu_opcode), 32'd0);
    check({tag, "_txd"}, 32'(bus.o_tx_data), 32'd0);
    check({tag, "_start"}, 32'(bus.o_tx_start), 32'd0);
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_ovr"}, 32'(bus.o_overrun), 32'd0);
    check({tag, "_tmo"}, 32'(bus.o_timeout), 32'd0);
    check({tag, "_state"}, 32'(bus.o_state), 32'(WAIT_A));
  endtask

  // directed vectors: a, b, opcode byte, expected result
  logic [7:0] dir_a[4]   = '{8'h03, 8'h80, 8'h80, 8'hF0};
  logic [7:0] dir_b[4]   = '{8'h05, 8'h01, 8'h01, 8'h0F};
  logic [7:0] dir_op[4]  = '{8'h22, 8'h03, 8'h02, 8'h27};
  logic [7:0] dir_exp[4] = '{8'hFE, 8'hC0, 8'h40, 8'h00};
  logic [5:0] ops[8]     = '{ADD, SUB, AND, OR, XOR, SRA, SRL, NOR};

  initial begin
    int n;
    logic [7:0] ra, rb, rop;
    logic [1:0] up;

    bus.i_rx_data  = '0;
    bus.i_rx_valid = 1'b0;
    bus.i_tx_done  = 1'b0;
    idle(3);
    check_cleared("reset");
    rst_n = 1'b1;
    idle(2);

    // ADD, then result held after completion
    send_cmd(8'h05, 8'h03, 8'h20, 1, 8'h08);
    finish_tx(2);
    check("tx_data_hold", 32'(bus.o_tx_data), 32'h08);

    // SUB / SRA / SRL / NOR
    for (int i = 0; i < 4; i++) begin
      send_cmd(dir_a[i], dir_b[i], dir_op[i], 0, dir_exp[i]);
      finish_tx(1 + i);
    end

    // abandoned command
    send_byte(8'h05);
    send_byte(8'h03);
    n = 0;
    while (n < 4 * T && !bus.o_timeout) begin
      @(negedge clk);
      n++;
    end
    exp_timeout++;
    check("timeout_latency", 32'(n), 32'(T));
    check("timeout_state", 32'(bus.o_state), 32'(WAIT_A));
    send_cmd(8'h01, 8'h01, 8'h20, 0, 8'h02);
    finish_tx(1);

    // bytes arriving exactly in the expiry cycle are accepted
    send_cmd(8'h11, 8'h22, 8'h20, T - 1, 8'h33);
    finish_tx(1);

    // done ignored outside WAIT_TX, then overrun in WAIT_TX
    send_cmd(8'h09, 8'h04, 8'h22, 0, 8'h05);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    check("done_in_send_ignored", 32'(bus.o_busy), 32'd1);
    send_byte(8'h55);
    exp_overrun++;
    check("overrun_pulse", 32'(bus.o_overrun), 32'd1);
    bus.i_rx_data  = 8'h55;
    bus.i_rx_valid = 1'b1;
    bus.i_tx_done  = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    bus.i_tx_done  = 1'b0;
    exp_overrun++;
    check("overrun_with_done", 32'(bus.o_overrun), 32'd1);
    check("busy_after_coincident", 32'(bus.o_busy), 32'd0);
    send_cmd(8'h02, 8'h02, 8'h24, 0, 8'h02);
    finish_tx(1);

    // reset during WAIT_OP
    send_byte(8'h21);
    send_byte(8'h43);
    rst_n = 1'b0;
    idle(2);
    check_cleared("rst_waitop");
    rst_n = 1'b1;
    idle(T + 4);

    // reset during WAIT_TX
    send_cmd(8'h33, 8'h44, 8'h20, 0, 8'h77);
    idle(1);
    rst_n = 1'b0;
    idle(2);
    check_cleared("rst_waittx");
    rst_n = 1'b1;
    idle(3);
    send_cmd(8'h0A, 8'h05, 8'h26, 0, 8'h0F);
    finish_tx(1);

    // upper opcode bits ignored; undefined opcode yields zero
    send_cmd(8'h7F, 8'h01, 8'hE0, 0, 8'h80);
    finish_tx(1);
    send_cmd(8'h12, 8'h34, 8'h3F, 0, 8'h00);
    finish_tx(1);

    // randomized commands
    for (int i = 0; i < 24; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      up  = 2'($urandom_range(0, 3));
      rop = {up, ops[$urandom_range(0, 7)]};
      send_cmd(ra, rb, rop, $urandom_range(0, T - 1), alu_ref(ra, rb, rop[5:0]));
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
        send_byte(8'($urandom_range(0, 255)));
        exp_overrun++;
      end
      finish_tx($urandom_range(1, 5));
      idle($urandom_range(0, 3));
    end

    idle(5);
    check("pending_results", 32'(exp_q.size()), 32'd0);
    check("overrun_count", 32'(seen_overrun), 32'(exp_overrun));
    check("timeout_count", 32'(seen_timeout), 32'(exp_timeout));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
Controller that sequences the shared combinational ALU from a byte stream. It collects three bytes from the UART receiver, in order: operand A, operand B, opcode. It then presents them to the ALU, captures the result and hands it to the UART transmitter, waiting for transmit completion before accepting the next command. It sits between uart_rx/uart_tx and the ALU in the top level.

Parameters:
NB_DATA, 8, width of operands, result and UART bytes
NB_OPCODE, 6, ALU opcode width; taken from the low bits of the opcode byte
TIMEOUT_CYCLES, 1000000, max idle clocks between bytes of one command before the command is abandoned
NB_TIMER, 20, width of inter-byte timer (must hold TIMEOUT_CYCLES)

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  NB_DATA  received byte, valid with i_rx_valid
i_rx_valid  in  1  single-cycle pulse: byte available
o_alu_a  out  NB_DATA  registered operand A to ALU
o_alu_b  out  NB_DATA  registered operand B to ALU
o_alu_opcode  out  NB_OPCODE  registered opcode to ALU
i_alu_result  in  NB_DATA  combinational ALU result
o_tx_data  out  NB_DATA  registered result byte to transmitter
o_tx_start  out  1  single-cycle pulse: start transmission
i_tx_done  in  1  single-cycle pulse: transmitter finished
o_busy  out  1  high in COMPUTE, SEND, WAIT_TX
o_overrun  out  1  single-cycle pulse: byte received while busy, dropped
o_timeout  out  1  single-cycle pulse: partial command abandoned

Behaviour:
- Reset (async assert, sync deassert handled at top): state=WAIT_A; all outputs 0; timer 0.
- States: WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND, WAIT_TX.
- WAIT_A: on i_rx_valid, load o_alu_a and go to WAIT_B. No timeout in this state.
- WAIT_B: on i_rx_valid, load o_alu_b and go to WAIT_OP.
- WAIT_OP: on i_rx_valid, load o_alu_opcode=i_rx_data[NB_OPCODE-1:0] and go to COMPUTE. Upper opcode byte bits are ignored.
- COMPUTE: one cycle. Operands are stable, so o_tx_data<=i_alu_result; go to SEND.
- SEND: o_tx_start=1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: hold until i_tx_done, then go to WAIT_A.
- Latency: opcode byte accepted at edge k; COMPUTE during cycle k+1; o_tx_start high and o_tx_data valid in cycle k+2.
- o_tx_data holds its value until the next COMPUTE.
- Timer: cleared on every accepted byte and in WAIT_A/busy states; counts in WAIT_B/WAIT_OP.
  - On reaching TIMEOUT_CYCLES-1 with no i_rx_valid: pulse o_timeout and go to WAIT_A.
  - Operand registers are not cleared.
  - If i_rx_valid coincides with expiry, the byte is accepted and no timeout occurs.
- Busy states: any i_rx_valid is dropped and o_overrun pulses next cycle.
  - This includes i_rx_valid coinciding with i_tx_done in WAIT_TX: the byte is dropped, the return to WAIT_A still happens, and o_overrun pulses.
- i_tx_done outside WAIT_TX is ignored.
- Unknown opcodes are passed through; the ALU yields 0 and 0x00 is transmitted.
- Reset mid-command or mid-transmit: immediate return to WAIT_A. o_tx_start is forced 0 and no result is sent.
- All outputs are registered; no combinational path from i_rx_* to outputs.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - State encoding localparams.
  - ALU opcode localparams ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111. The ALU and the bench import the same values.
- One sub-module, inter_byte_timer: clear/enable inputs, single-cycle expired output.
- The FSM and datapath registers stay in alu_uart_sequencer.

Test Plan:
- Bytes 0x05, 0x03, 0x20 (ADD) with a model ALU → o_tx_start pulses 2 cycles after the 3rd byte with o_tx_data=0x08. After i_tx_done, o_busy=0.
- 0x03, 0x05, 0x22 (SUB) → 0xFE. Then 0x80, 0x01, 0x03 (SRA) → 0xC0. Then 0x80, 0x01, 0x02 (SRL) → 0x40. Then 0xF0, 0x0F, 0x27 (NOR) → 0x00.
- 0x05, 0x03, then idle TIMEOUT_CYCLES (bench sets 16) → o_timeout pulse, state WAIT_A. Next bytes 0x01, 0x01, 0x20 → result 0x02.
- Full command, then a byte 0x55 during WAIT_TX, including one cycle coincident with i_tx_done → o_overrun pulses and the byte is dropped. The next command 0x02, 0x02, 0x24 (AND) → 0x02.
- Assert i_reset during WAIT_OP and again during WAIT_TX → outputs 0 and no o_tx_start. The next command 0x0A, 0x05, 0x26 (XOR) → 0x0F.
- Opcode byte 0xE0 (upper bits set, low bits ADD) with 0x7F, 0x01 → 0x80. Opcode 0x3F (undefined) → 0x00.
